matmul_sequencer: RTL and testbench

Sequencer for the matrix-multiply datapath. Consumes the start bit and the N/K/M, mode and target fields published by the control register block. Walks every output element C[i][j] through accumulate-clear, K-step multiply-accumulate, optional bias read and scratchpad write, and pulses the start-bit de-assert back to the control register. Sits between the control register and the PE/scratchpad datapath; it stalls on datapath ready signals.

---
 rtl/matmul_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Purpose: walks every C[i][j] of an (N+1)x(M+1) result through clear, (K+1) MAC steps, optional bias read and write.
// Latency: LATCH..DONE = 2 + (N+1)(M+1)(K+3+b) cycles with no stalls; b=1 when bias is enabled and latched mode=1.
// Backpressure: holds in MAC while mac_ready_i=0 and in WRITE while wr_ready_i=0; all outputs are Moore-decoded.
//
// Optional feature macro: MATMUL_SEQ_BIAS_EN (adds the BIAS state; when undefined mode_bit_i and
// read_target_i are ignored and bias_rd_en_o / bias_target_o stay 0).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_bit_i, mode_bit_i       control register bit 0 (start) and bit 1 (bias-add enable)
//   N_i, K_i, M_i                 encoded dimensions (d means d+1 elements)
//   write_target_i, read_target_i scratchpad targets for C and for the bias
//   mac_ready_i, wr_ready_i       datapath / scratchpad accept
//   clear_start_o                 one-cycle pulse clearing the start bit
//   busy_o, done_o                in-progress level, one-cycle completion pulse
//   acc_clear_o, acc_en_o         accumulator clear, MAC step valid
//   a_row_o, b_col_o, k_idx_o     current i, j, k
//   bias_rd_en_o, bias_target_o   bias read strobe and latched bias target
//   wr_en_o, wr_target_o          write request for C[i][j] and latched C target
module matmul_sequencer #(
    parameter int DIM_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_bit_i,
    input  logic             mode_bit_i,
    input  logic [DIM_W-1:0] N_i,
    input  logic [DIM_W-1:0] K_i,
    input  logic [DIM_W-1:0] M_i,
    input  logic [1:0]       write_target_i,
    input  logic [1:0]       read_target_i,
    input  logic             mac_ready_i,
    input  logic             wr_ready_i,
    output logic             clear_start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             acc_clear_o,
    output logic             acc_en_o,
    output logic [DIM_W-1:0] a_row_o,
    output logic [DIM_W-1:0] b_col_o,
    output logic [DIM_W-1:0] k_idx_o,
    output logic             bias_rd_en_o,
    output logic [1:0]       bias_target_o,
    output logic [1:0]       wr_target_o,
    output logic             wr_en_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_CLR   = 3'd2,
        ST_MAC   = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
`ifdef MATMUL_SEQ_BIAS_EN
        ,
        ST_BIAS  = 3'd6
`endif
    } state_t;

    state_t state_q, state_d;

    // Copies taken on the edge that accepts the start request, while busy_o is
    // still low, so field changes during the run never reach the walk.
    logic [DIM_W-1:0] n_lat_q, k_lat_q, m_lat_q;
    logic [1:0]       wt_lat_q;
    logic [DIM_W-1:0] i_q, j_q, k_q;

    logic last_i, last_j, last_k;
    assign last_i = (i_q == n_lat_q);
    assign last_j = (j_q == m_lat_q);
    assign last_k = (k_q == k_lat_q);

`ifdef MATMUL_SEQ_BIAS_EN
    logic       mode_lat_q;
    logic [1:0] rt_lat_q;
`else
    // Inputs that only matter when the bias path is built in.
    logic [2:0] unused_bias_inputs;
    assign unused_bias_inputs = {mode_bit_i, read_target_i};
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_bit_i) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_CLR;
            ST_CLR:   state_d = ST_MAC;
            ST_MAC: begin
                if (mac_ready_i && last_k) begin
`ifdef MATMUL_SEQ_BIAS_EN
                    state_d = mode_lat_q ? ST_BIAS : ST_WRITE;
`else
                    state_d = ST_WRITE;
`endif
                end
            end
`ifdef MATMUL_SEQ_BIAS_EN
            ST_BIAS:  state_d = ST_WRITE;
`endif
            ST_WRITE: begin
                if (wr_ready_i) state_d = (last_i && last_j) ? ST_DONE : ST_CLR;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and latched fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            n_lat_q  <= '0;
            k_lat_q  <= '0;
            m_lat_q  <= '0;
            wt_lat_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
`ifdef MATMUL_SEQ_BIAS_EN
            mode_lat_q <= 1'b0;
            rt_lat_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_bit_i) begin
                        n_lat_q  <= N_i;
                        k_lat_q  <= K_i;
                        m_lat_q  <= M_i;
                        wt_lat_q <= write_target_i;
`ifdef MATMUL_SEQ_BIAS_EN
                        mode_lat_q <= mode_bit_i;
                        rt_lat_q   <= read_target_i;
`endif
                    end
                end
                ST_LATCH: begin
                    i_q <= '0;
                    j_q <= '0;
                    k_q <= '0;
                end
                ST_CLR: k_q <= '0;
                ST_MAC: begin
                    // k saturates at the latched bound; the exit is taken instead.
                    if (mac_ready_i && !last_k) k_q <= k_q + DIM_W'(1);
                end
                ST_WRITE: begin
                    if (wr_ready_i) begin
                        k_q <= '0;
                        if (!last_j) begin
                            j_q <= j_q + DIM_W'(1);
                        end else if (!last_i) begin
                            j_q <= '0;
                            i_q <= i_q + DIM_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Return the address outputs to 0 while idle.
                    i_q <= '0;
                    j_q <= '0;
                    k_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs: decoded from registered state and counters only
    // ------------------------------------------------------------------
    assign clear_start_o = (state_q == ST_LATCH);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign acc_clear_o   = (state_q == ST_CLR);
    assign acc_en_o      = (state_q == ST_MAC);
    assign wr_en_o       = (state_q == ST_WRITE);
    assign a_row_o       = i_q;
    assign b_col_o       = j_q;
    assign k_idx_o       = k_q;
    assign wr_target_o   = wt_lat_q;

`ifdef MATMUL_SEQ_BIAS_EN
    assign bias_rd_en_o  = (state_q == ST_BIAS);
    assign bias_target_o = rt_lat_q;
`else
    assign bias_rd_en_o  = 1'b0;
    assign bias_target_o = 2'b00;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Purpose: scoreboard bench for matmul_sequencer; a reference walk per run is queued, a monitor pops on DUT events.
// Latency: each run is bounded by a cycle budget; expected span is derived from the element/step arithmetic.
// Backpressure: ready inputs are driven per cycle by a pattern process (always high, random, alternating, write hold).
module tb_matmul_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_bit_i, mode_bit_i;
    logic [1:0] N_i, K_i, M_i, write_target_i, read_target_i;
    logic       mac_ready_i, wr_ready_i;
    logic       clear_start_o, busy_o, done_o, acc_clear_o, acc_en_o;
    logic [1:0] a_row_o, b_col_o, k_idx_o;
    logic       bias_rd_en_o;
    logic [1:0] bias_target_o, wr_target_o;
    logic       wr_en_o;

    matmul_sequencer #(.DIM_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .start_bit_i(start_bit_i), .mode_bit_i(mode_bit_i),
        .N_i(N_i), .K_i(K_i), .M_i(M_i),
        .write_target_i(write_target_i), .read_target_i(read_target_i),
        .mac_ready_i(mac_ready_i), .wr_ready_i(wr_ready_i),
        .clear_start_o(clear_start_o), .busy_o(busy_o), .done_o(done_o),
        .acc_clear_o(acc_clear_o), .acc_en_o(acc_en_o),
        .a_row_o(a_row_o), .b_col_o(b_col_o), .k_idx_o(k_idx_o),
        .bias_rd_en_o(bias_rd_en_o), .bias_target_o(bias_target_o),
        .wr_target_o(wr_target_o), .wr_en_o(wr_en_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int EV_CS = 0, EV_CLR = 1, EV_MAC = 2, EV_BIAS = 3, EV_WR = 4, EV_DONE = 5;

    typedef struct {
        int kind;
        int i;
        int j;
        int k;
        int t;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  rdy_mode = 0;
    int  wr_low = 0;
    bit  mac_tog = 1'b0;

`ifdef MATMUL_SEQ_BIAS_EN
    localparam bit BIAS_BUILT = 1'b1;
`else
    localparam bit BIAS_BUILT = 1'b0;
`endif

    // Reference walk: i outer, j middle, k inner; cycle count from the element arithmetic.
    task automatic push_run(input int n, input int k, input int m, input int md, input int wt, input int rt);
        int  b;
        ev_t e;
        b = (BIAS_BUILT && md != 0) ? 1 : 0;
        e = '{EV_CS, 0, 0, 0, wt, 0};
        exp_q.push_back(e);
        for (int i = 0; i <= n; i++) begin
            for (int j = 0; j <= m; j++) begin
                e = '{EV_CLR, i, j, 0, wt, 0};
                exp_q.push_back(e);
                for (int kk = 0; kk <= k; kk++) begin
                    e = '{EV_MAC, i, j, kk, wt, 0};
                    exp_q.push_back(e);
                end
                if (b == 1) begin
                    e = '{EV_BIAS, i, j, k, rt, 0};
                    exp_q.push_back(e);
                end
                e = '{EV_WR, i, j, k, wt, 0};
                exp_q.push_back(e);
            end
        end
        e = '{EV_DONE, 0, 0, 0, BIAS_BUILT ? rt : 0, 2 + (n + 1) * (m + 1) * (k + 3 + b)};
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int i, input int j, input int k, input int t, input int cyc);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ev_unexpected: actual kind=%0d i=%0d j=%0d k=%0d t=%0d required no event", kind, i, j, k, t);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.i != i || e.j != j || e.k != k || e.t != t || e.cyc != cyc) begin
                errors++;
                $display("FAIL ev_seq: actual kind=%0d i=%0d j=%0d k=%0d t=%0d cyc=%0d required kind=%0d i=%0d j=%0d k=%0d t=%0d cyc=%0d",
                         kind, i, j, k, t, cyc, e.kind, e.i, e.j, e.k, e.t, e.cyc);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, pops the scoreboard per event
    // ------------------------------------------------------------------
    int         span = 0, stalls = 0;
    logic       p_mac_stall = 1'b0, p_wr_stall = 1'b0, p_done = 1'b0;
    logic [1:0] p_i = '0, p_j = '0, p_k = '0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            p_mac_stall = 1'b0;
            p_wr_stall  = 1'b0;
            p_done      = 1'b0;
            span        = 0;
            stalls      = 0;
        end else begin
            if (p_mac_stall) begin
                checks++;
                if (!(acc_en_o && k_idx_o == p_k && a_row_o == p_i && b_col_o == p_j)) begin
                    errors++;
                    $display("FAIL mac_hold: actual en=%0b i=%0d j=%0d k=%0d required en=1 i=%0d j=%0d k=%0d",
                             acc_en_o, a_row_o, b_col_o, k_idx_o, p_i, p_j, p_k);
                end
            end
            if (p_wr_stall) begin
                checks++;
                if (!(wr_en_o && a_row_o == p_i && b_col_o == p_j)) begin
                    errors++;
                    $display("FAIL wr_hold: actual en=%0b i=%0d j=%0d required en=1 i=%0d j=%0d",
                             wr_en_o, a_row_o, b_col_o, p_i, p_j);
                end
            end
            if (p_done) begin
                checks++;
                if (busy_o) begin
                    errors++;
                    $display("FAIL busy_after_done: actual busy=1 required busy=0");
                end
            end
            if (clear_start_o) begin
                span   = 1;
                stalls = 0;
                check_ev(EV_CS, int'(a_row_o), int'(b_col_o), int'(k_idx_o), int'(wr_target_o), 0);
            end else if (busy_o) begin
                span++;
            end
            if ((acc_en_o && !mac_ready_i) || (wr_en_o && !wr_ready_i)) stalls++;
            if (acc_clear_o)
                check_ev(EV_CLR, int'(a_row_o), int'(b_col_o), int'(k_idx_o), int'(wr_target_o), 0);
            if (acc_en_o && mac_ready_i)
                check_ev(EV_MAC, int'(a_row_o), int'(b_col_o), int'(k_idx_o), int'(wr_target_o), 0);
            if (bias_rd_en_o)
                check_ev(EV_BIAS, int'(a_row_o), int'(b_col_o), int'(k_idx_o), int'(bias_target_o), 0);
            if (wr_en_o && wr_ready_i)
                check_ev(EV_WR, int'(a_row_o), int'(b_col_o), int'(k_idx_o), int'(wr_target_o), 0);
            if (done_o)
                check_ev(EV_DONE, 0, 0, 0, int'(bias_target_o), span - stalls);
            p_mac_stall = acc_en_o && !mac_ready_i;
            p_wr_stall  = wr_en_o && !wr_ready_i;
            p_done      = done_o;
            p_i         = a_row_o;
            p_j         = b_col_o;
            p_k         = k_idx_o;
        end
    end

    // ------------------------------------------------------------------
    // Ready pattern driver
    // ------------------------------------------------------------------
    initial begin
        mac_ready_i = 1'b1;
        wr_ready_i  = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                1: begin
                    mac_ready_i = ($urandom_range(0, 3) != 0);
                    wr_ready_i  = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    wr_ready_i = 1'b1;
                    if (acc_en_o) begin
                        mac_ready_i = mac_tog;
                        mac_tog     = !mac_tog;
                    end else begin
                        mac_ready_i = 1'b1;
                    end
                end
                3: begin
                    mac_ready_i = 1'b1;
                    if (wr_en_o && a_row_o == 2'd0 && b_col_o == 2'd0 && wr_low < 3) begin
                        wr_ready_i = 1'b0;
                        wr_low++;
                    end else begin
                        wr_ready_i = 1'b1;
                    end
                end
                default: begin
                    mac_ready_i = 1'b1;
                    wr_ready_i  = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_fields(input int n, input int k, input int m, input int md, input int wt, input int rt);
        N_i            = 2'(n);
        K_i            = 2'(k);
        M_i            = 2'(m);
        mode_bit_i     = (md != 0);
        write_target_i = 2'(wt);
        read_target_i  = 2'(rt);
    endtask

    task automatic wait_cs();
        int n;
        n = 0;
        while (!clear_start_o && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checks++;
        if (!clear_start_o) begin
            errors++;
            $display("FAIL cs_timeout: actual clear_start=0 required 1 within 50 cycles");
        end
        start_bit_i = 1'b0;
    endtask

    // Finishes a run; optionally scrambles the inputs while busy to prove the latched copies are used.
    task automatic wait_done(input bit scramble);
        int n;
        n = 0;
        while (!done_o && n < 2000) begin
            @(posedge clk_i);
            #1;
            n++;
            if (scramble) set_fields($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                                     $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        checks++;
        if (!done_o) begin
            errors++;
            $display("FAIL done_timeout: actual done=0 required 1 within 2000 cycles");
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d events left required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic run_op(input int n, input int k, input int m, input int md, input int wt, input int rt,
                          input bit scramble);
        set_fields(n, k, m, md, wt, rt);
        start_bit_i = 1'b1;
        push_run(n, k, m, md, wt, rt);
        wait_cs();
        wait_done(scramble);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        logic [17:0] outs;
        outs = {clear_start_o, busy_o, done_o, acc_clear_o, acc_en_o, a_row_o, b_col_o, k_idx_o,
                bias_rd_en_o, bias_target_o, wr_target_o, wr_en_o};
        checks++;
        if (outs != 18'd0) begin
            errors++;
            $display("FAIL %s: actual outputs=%05h required 00000", name, outs);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int nn, kk, mm, md, wt, rt;
        rst_i       = 1'b1;
        start_bit_i = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset_state");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Smallest operation, then 2x2x2 without and with bias.
        run_op(0, 0, 0, 0, 1, 2, 1'b0);
        run_op(1, 1, 1, 0, 2, 3, 1'b0);
        run_op(1, 1, 1, 1, 3, 1, 1'b0);

        // MAC stalls on alternate cycles.
        rdy_mode = 2;
        mac_tog  = 1'b0;
        run_op(0, 3, 0, 0, 1, 1, 1'b0);

        // Write held off for three cycles on element (0,0).
        rdy_mode = 3;
        wr_low   = 0;
        run_op(1, 0, 1, 1, 2, 2, 1'b0);

        // Random shapes, random backpressure, inputs scrambled while busy.
        rdy_mode = 1;
        for (int r = 0; r < 10; r++) begin
            run_op($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end

        // Reset during MAC of element (1,0) with start held and N changed.
        rdy_mode = 0;
        set_fields(1, 2, 1, 1, 3, 2);
        start_bit_i = 1'b1;
        push_run(1, 2, 1, 1, 3, 2);
        wait_cs();
        start_bit_i = 1'b1;
        n = 0;
        while (!(acc_en_o && a_row_o == 2'd1 && b_col_o == 2'd0) && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checks++;
        if (!(acc_en_o && a_row_o == 2'd1 && b_col_o == 2'd0)) begin
            errors++;
            $display("FAIL reach_mac_10: actual en=%0b i=%0d j=%0d required en=1 i=1 j=0", acc_en_o, a_row_o, b_col_o);
        end
        rst_i = 1'b1;
        nn = 0; kk = 1; mm = 2; md = 0; wt = 1; rt = 3;
        set_fields(nn, kk, mm, md, wt, rt);
        @(posedge clk_i);
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        rst_i = 1'b0;
        // Start is still high, so the run restarts from IDLE with the new fields.
        push_run(nn, kk, mm, md, wt, rt);
        wait_cs();
        wait_done(1'b1);

        // A further run after the scrambled one must use only its own fields.
        run_op(2, 1, 0, 1, 2, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
